// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C configuration writer.
// bus_pattern gives the {scl, sda_oe} levels for each quarter of every bit time.
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_BIT     = 3'd2,
    S_ACK     = 3'd3,
    S_STOP    = 3'd4,
    S_BUSFREE = 3'd5
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic W_BIT = 1'b0;

  // Returns {scl, sda_oe} for a state, a quarter and the data bit being sent.
  function automatic logic [1:0] bus_pattern(input state_t st, input logic [1:0] q,
                                             input logic b);
    logic hi;
    hi = (q == Q1) || (q == Q2);
    case (st)
      S_START: return {1'b1, (q == Q2) || (q == Q3)};
      S_BIT:   return {hi, ~b};
      S_ACK:   return {hi, 1'b0};
      S_STOP: begin
        case (q)
          Q0:      return 2'b01;
          Q1:      return 2'b11;
          default: return 2'b10;
        endcase
      end
      default: return 2'b10;
    endcase
  endfunction

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-bit timebase: CLK_DIV-cycle divider feeding a 2-bit quarter index.
// Both counters sit at zero whenever enable is low.
module i2c_qtick
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       enable,
  output logic       tick,
  output logic [1:0] q
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;

  assign tick = enable && (div == DIV_MAX);

  always_ff @(posedge CLK) begin
    if (!RST || !enable) begin
      div <= '0;
      q   <= Q0;
    end else if (tick) begin
      div <= '0;
      q   <= q + 2'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_cfg_writer.sv
// I2C master write engine: START, address+W, NUM_BYTES payload bytes, STOP,
// with per-byte ACK sampling and bounded retry on NACK.
module i2c_cfg_writer
  import i2c_pkg::*;
#(
  parameter int         CLK_DIV   = 4,
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         NUM_BYTES = 2,
  parameter int         MAX_RETRY = 3
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   start,
  input  logic [8*NUM_BYTES-1:0] wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   ack_err,
  output logic                   scl,
  output logic                   sda_oe,
  input  logic                   sda_i
);

  localparam int SR_W = 8 * (NUM_BYTES + 1);

  state_t                 state;
  logic [SR_W-1:0]        sr;
  logic [8*NUM_BYTES-1:0] latched;
  logic [2:0]             bcnt;
  logic [2:0]             byte_cnt;
  logic [2:0]             retry;
  logic                   nack;
  logic                   tick;
  logic [1:0]             q;

  i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
    .CLK    (CLK),
    .RST    (RST),
    .enable (state != S_IDLE),
    .tick   (tick),
    .q      (q)
  );

  // Pin registers are loaded one cycle ahead with the pattern of the quarter
  // that starts on the next edge, so scl/sda_oe line up exactly with q.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
      scl      <= 1'b1;
      sda_oe   <= 1'b0;
      retry    <= '0;
      nack     <= 1'b0;
      bcnt     <= 3'd7;
      byte_cnt <= '0;
    end else begin
      done    <= 1'b0;
      ack_err <= 1'b0;
      case (state)
        S_IDLE: begin
          // done is still high in the cycle after completion; a start there is dropped.
          if (start && !done) begin
            state        <= S_START;
            busy         <= 1'b1;
            retry        <= '0;
            nack         <= 1'b0;
            latched      <= wr_data;
            sr           <= {DEV_ADDR, W_BIT, wr_data};
            {scl, sda_oe} <= bus_pattern(S_START, Q0, 1'b0);
          end
        end
        S_START, S_BIT, S_ACK, S_STOP, S_BUSFREE: begin
          if (tick) begin
            if (state == S_ACK && q == Q2)
              nack <= sda_i;
            if (q != Q3) begin
              {scl, sda_oe} <= bus_pattern(state, q + 2'd1, sr[SR_W-1]);
            end else begin
              case (state)
                S_START: begin
                  state         <= S_BIT;
                  bcnt          <= 3'd7;
                  byte_cnt      <= '0;
                  {scl, sda_oe} <= bus_pattern(S_BIT, Q0, sr[SR_W-1]);
                end
                S_BIT: begin
                  sr <= sr << 1;
                  if (bcnt == 3'd0) begin
                    state         <= S_ACK;
                    {scl, sda_oe} <= bus_pattern(S_ACK, Q0, 1'b0);
                  end else begin
                    bcnt          <= bcnt - 3'd1;
                    {scl, sda_oe} <= bus_pattern(S_BIT, Q0, sr[SR_W-2]);
                  end
                end
                S_ACK: begin
                  if (nack || byte_cnt == 3'(NUM_BYTES)) begin
                    state         <= S_STOP;
                    {scl, sda_oe} <= bus_pattern(S_STOP, Q0, 1'b0);
                  end else begin
                    state         <= S_BIT;
                    bcnt          <= 3'd7;
                    byte_cnt      <= byte_cnt + 3'd1;
                    {scl, sda_oe} <= bus_pattern(S_BIT, Q0, sr[SR_W-1]);
                  end
                end
                S_STOP: begin
                  {scl, sda_oe} <= 2'b10;
                  if (!nack) begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                  end else if (retry < 3'(MAX_RETRY)) begin
                    state <= S_BUSFREE;
                    retry <= retry + 3'd1;
                    nack  <= 1'b0;
                    sr    <= {DEV_ADDR, W_BIT, latched};
                  end else begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    ack_err <= 1'b1;
                  end
                end
                S_BUSFREE: begin
                  state         <= S_START;
                  {scl, sda_oe} <= bus_pattern(S_START, Q0, 1'b0);
                end
                default: state <= S_IDLE;
              endcase
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          scl    <= 1'b1;
          sda_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cfg_writer.sv
// Self-checking bench for i2c_cfg_writer: bus monitor, ACK/NACK slave model,
// byte scoreboard, latency and bus-timing checks, plus reset/abort sequences.
module tb_i2c_cfg_writer;

  localparam int CLK_DIV   = 2;
  localparam int NUM_BYTES = 2;
  localparam int MAX_RETRY = 3;
  localparam int BT        = 4 * CLK_DIV;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [15:0] wr_data = 16'h0;
  logic        sda_i;
  logic        busy, done, ack_err, scl, sda_oe;

  int n_vec  = 0;
  int n_fail = 0;

  // Slave behaviour: 0 ACK all, 1 NACK address on attempt 1, 2 NACK always,
  // 3 NACK last data byte on attempt 1.
  int mode       = 0;
  int start_base = 0;

  i2c_cfg_writer #(
    .CLK_DIV   (CLK_DIV),
    .DEV_ADDR  (7'h1A),
    .NUM_BYTES (NUM_BYTES),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .start   (start),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err),
    .scl     (scl),
    .sda_oe  (sda_oe),
    .sda_i   (sda_i)
  );

  always #5 CLK = ~CLK;

  logic       prev_scl = 1'b1;
  logic       prev_oe  = 1'b0;
  int         hi_len   = 0;
  logic       hi_rise  = 1'b0;
  logic       hi_start = 1'b0;
  int         starts   = 0;
  int         stops    = 0;
  int         bitn     = 0;
  logic [7:0] bsr      = 8'h0;
  logic [7:0] got_q[$];
  int         hi_q[$];

  function automatic logic slave_nack(input int m, input int attempt, input int bn);
    int slot;
    if (bn == 0 || (bn % 9) != 0) return 1'b0;
    slot = bn / 9 - 1;
    case (m)
      1:       return (attempt == 1) && (slot == 0);
      2:       return 1'b1;
      3:       return (attempt == 1) && (slot == NUM_BYTES);
      default: return 1'b0;
    endcase
  endfunction

  assign sda_i = slave_nack(mode, starts - start_base, bitn);

  // Bus monitor: classifies SDA edges under high SCL as START/STOP, captures
  // bits on SCL rise, and records the length of each normal SCL high phase.
  initial begin
    forever begin
      @(negedge CLK);
      if (scl === 1'b1 && prev_scl === 1'b1 && sda_oe !== prev_oe) begin
        if (sda_oe) begin
          starts++;
          bitn     = 0;
          hi_start = 1'b1;
        end else begin
          stops++;
        end
      end
      if (scl === 1'b1 && prev_scl === 1'b0) begin
        hi_len   = 1;
        hi_rise  = 1'b1;
        hi_start = 1'b0;
        bsr      = {bsr[6:0], ~sda_oe};
        bitn++;
        if ((bitn % 9) == 8) got_q.push_back(bsr);
      end else if (scl === 1'b1) begin
        hi_len++;
      end else if (prev_scl === 1'b1) begin
        if (hi_rise && !hi_start) hi_q.push_back(hi_len);
        hi_rise = 1'b0;
      end
      prev_scl = scl;
      prev_oe  = sda_oe;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run_txn(input logic [15:0] d, input int m, input int exp_cyc,
                         input logic exp_err, input int exp_starts, input bit poke,
                         input string tag);
    int         cyc;
    bit         seen;
    int         stop_base;
    int         n;
    logic [7:0] exp_q[$];
    mode       = m;
    start_base = starts;
    stop_base  = stops;
    got_q.delete();
    hi_q.delete();
    case (m)
      1: begin
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h34); exp_q.push_back(d[15:8]); exp_q.push_back(d[7:0]);
      end
      2: repeat (MAX_RETRY + 1) exp_q.push_back(8'h34);
      3: repeat (2) begin
        exp_q.push_back(8'h34); exp_q.push_back(d[15:8]); exp_q.push_back(d[7:0]);
      end
      default: begin
        exp_q.push_back(8'h34); exp_q.push_back(d[15:8]); exp_q.push_back(d[7:0]);
      end
    endcase

    @(negedge CLK);
    wr_data = d;
    start   = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    chk({tag, "_busy_accept"}, busy, 1);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < exp_cyc + 200) begin
      @(posedge CLK); #1;
      cyc++;
      start = 1'b0;
      if (done) seen = 1;
      else if (poke && (cyc % 37) == 5) begin
        start   = 1'b1;
        wr_data = 16'($urandom);
      end
    end
    chk({tag, "_latency"}, seen ? cyc : -1, exp_cyc);
    chk({tag, "_ack_err"}, ack_err, exp_err);
    chk({tag, "_busy_done"}, busy, 0);
    if (poke) start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_err_pulse"}, ack_err, 0);
    chk({tag, "_scl_idle"}, scl, 1);
    chk({tag, "_oe_idle"}, sda_oe, 0);
    if (poke) begin
      repeat (2 * BT) @(posedge CLK);
      #1;
      chk({tag, "_no_extra_txn"}, busy, 0);
    end
    chk({tag, "_starts"}, starts - start_base, exp_starts);
    chk({tag, "_stops"}, stops - stop_base, exp_starts);
    chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    chk({tag, "_hi_phases"}, (hi_q.size() > 0) ? 1 : 0, 1);
    foreach (hi_q[i]) chk($sformatf("%s_hi%0d", tag, i), hi_q[i], 2 * CLK_DIV);
  endtask

  typedef struct {
    logic [15:0] data;
    int          m;
    int          cycles;
    logic        err;
    int          nstart;
    bit          poke;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  wait_cyc;
    bit  saw_done;
    tbl[0] = '{16'h0579, 0, 232, 1'b0, 1, 1'b0};
    tbl[1] = '{16'hA5C3, 1, 328, 1'b0, 2, 1'b0};
    tbl[2] = '{16'hFF00, 2, 376, 1'b1, 4, 1'b0};
    tbl[3] = '{16'h1234, 3, 472, 1'b0, 2, 1'b1};
    tbl[4] = '{16'h8001, 0, 232, 1'b0, 1, 1'b1};

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_err", ack_err, 0);
    chk("rst_scl", scl, 1);
    chk("rst_sda_oe", sda_oe, 0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 5; i++)
      run_txn(tbl[i].data, tbl[i].m, tbl[i].cycles, tbl[i].err, tbl[i].nstart,
              tbl[i].poke, $sformatf("vec%0d", i));

    // Abort in the middle of the first payload byte.
    mode = 0;
    @(negedge CLK);
    wr_data = 16'hC3A5;
    start   = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    chk("abort_busy_accept", busy, 1);
    repeat (BT + 9 * BT + 4 * BT + 3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("abort_scl", scl, 1);
    chk("abort_sda_oe", sda_oe, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge CLK);
    RST = 1'b1;
    saw_done = 0;
    for (wait_cyc = 0; wait_cyc < 5 * BT; wait_cyc++) begin
      @(posedge CLK); #1;
      if (done || busy) saw_done = 1;
    end
    chk("abort_quiet", saw_done, 0);
    run_txn(16'h0579, 0, 232, 1'b0, 1, 1'b0, "post_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
